cache_refill_controller: RTL and testbench

- Memory-side companion to DirectMappedCache; services its misses.
- On a miss request it first writes back the dirty victim line to backing memory, one block per beat, if the line is dirty.
- It then fetches the requested line block by block.
- Finally it installs the line into the cache via a one-cycle write_line pulse with the assembled line and fill address.

---
 rtl/cache_refill_controller.sv | 143 ++++++++++++++
 tb/tb_cache_refill_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_controller.sv
// Purpose: refill engine behind a direct-mapped cache. Writes back a dirty victim line, fetches the missing line, then installs it.
// Latency: a clean miss with zero-wait memory pulses write_line N cycles after accept and done one cycle later. A dirty victim adds N cycles.
// Backpressure: every memory beat holds mem_req/mem_we/mem_addr/mem_wdata steady until mem_ack. miss_req is accepted only when idle.
// Ports:
//   clk, rst (sync, active-high)
//   miss_req/miss_address, victim_dirty/victim_tag/victim_line : miss request from the cache
//   busy, write_line, line_o, fill_address, done              : status and install port to the cache
//   mem_req, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata  : block-wide beat interface to backing memory
module cache_refill_controller #(
  parameter int BLOCK_SIZE             = 4,
  parameter int NUM_OF_BLOCKS_PER_LINE = 2,
  parameter int NUM_OF_CACHE_LINES     = 4,
  parameter int ADDRESS_SIZE           = 16,
  localparam int BLOCK_OFFSET_LENGTH   = $clog2(NUM_OF_BLOCKS_PER_LINE),
  localparam int INDEX_LENGTH          = $clog2(NUM_OF_CACHE_LINES),
  localparam int TAG_LENGTH            = ADDRESS_SIZE - BLOCK_OFFSET_LENGTH - INDEX_LENGTH,
  localparam int LINE_W                = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_req,
  input  logic [ADDRESS_SIZE-1:0] miss_address,
  input  logic                    victim_dirty,
  input  logic [TAG_LENGTH-1:0]   victim_tag,
  input  logic [LINE_W-1:0]       victim_line,
  output logic                    busy,
  output logic                    write_line,
  output logic [LINE_W-1:0]       line_o,
  output logic [ADDRESS_SIZE-1:0] fill_address,
  output logic                    done,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0]   mem_wdata,
  input  logic                    mem_ack,
  input  logic [BLOCK_SIZE-1:0]   mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    FILL,
    INSTALL,
    DONE
  } state_t;

  state_t                         state;
  logic [BLOCK_OFFSET_LENGTH-1:0] beat;
  logic [TAG_LENGTH-1:0]          tag_q;
  logic [INDEX_LENGTH-1:0]        index_q;
  logic [TAG_LENGTH-1:0]          victim_tag_q;
  logic [LINE_W-1:0]              victim_q;
  logic [LINE_W-1:0]              line_buf;

  logic                           last_beat;
  logic [LINE_W-1:0]              line_buf_next;
  logic [BLOCK_SIZE-1:0]          victim_block;

  // The block offset of the missing address is irrelevant: whole lines are refilled from offset 0.
  logic unused_offset;
  assign unused_offset = &{1'b0, miss_address[BLOCK_OFFSET_LENGTH-1:0]};

  assign last_beat = (beat == BLOCK_OFFSET_LENGTH'(NUM_OF_BLOCKS_PER_LINE - 1));

  // Line buffer with the current beat's read data merged in. This lets the last beat go straight into line_o on the same edge.
  always_comb begin
    line_buf_next = line_buf;
    victim_block  = '0;
    for (int k = 0; k < NUM_OF_BLOCKS_PER_LINE; k++) begin
      if (beat == BLOCK_OFFSET_LENGTH'(k)) begin
        line_buf_next[k*BLOCK_SIZE +: BLOCK_SIZE] = mem_rdata;
        victim_block = victim_q[k*BLOCK_SIZE +: BLOCK_SIZE];
      end
    end
  end

  // Every output below is decoded from registers only, so beats stay stable across wait states.
  assign busy       = (state != IDLE);
  assign write_line = (state == INSTALL);
  assign done       = (state == DONE);
  assign mem_req    = (state == WRITEBACK) || (state == FILL);
  assign mem_we     = (state == WRITEBACK);
  assign mem_wdata  = (state == WRITEBACK) ? victim_block : '0;

  always_comb begin
    mem_addr = '0;
    if (state == WRITEBACK) mem_addr = {victim_tag_q, index_q, beat};
    else if (state == FILL) mem_addr = {tag_q, index_q, beat};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      beat         <= '0;
      tag_q        <= '0;
      index_q      <= '0;
      victim_tag_q <= '0;
      victim_q     <= '0;
      line_buf     <= '0;
      line_o       <= '0;
      fill_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_req) begin
            tag_q        <= miss_address[ADDRESS_SIZE-1 -: TAG_LENGTH];
            index_q      <= miss_address[BLOCK_OFFSET_LENGTH +: INDEX_LENGTH];
            victim_tag_q <= victim_tag;
            victim_q     <= victim_line;
            beat         <= '0;
            state        <= victim_dirty ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            if (last_beat) begin
              beat  <= '0;
              state <= FILL;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            line_buf <= line_buf_next;
            // The counter wraps to 0 after the last beat.
            beat     <= beat + 1'b1;
            if (last_beat) begin
              line_o       <= line_buf_next;
              fill_address <= {tag_q, index_q, {BLOCK_OFFSET_LENGTH{1'b0}}};
              state        <= INSTALL;
            end
          end
        end
        INSTALL: state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_controller.sv
module tb_cache_refill_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [15:0] miss_address;
  logic        victim_dirty;
  logic [12:0] victim_tag;
  logic [7:0]  victim_line;
  logic        busy;
  logic        write_line;
  logic [7:0]  line_o;
  logic [15:0] fill_address;
  logic        done;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [3:0]  mem_wdata;
  logic        mem_ack;
  logic [3:0]  mem_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wl_cnt   = 0;
  int done_cnt = 0;
  int t0       = 0;
  int wl_before;
  int done_before;

  cache_refill_controller dut (
    .clk          (clk),
    .rst          (rst),
    .miss_req     (miss_req),
    .miss_address (miss_address),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .victim_line  (victim_line),
    .busy         (busy),
    .write_line   (write_line),
    .line_o       (line_o),
    .fill_address (fill_address),
    .done         (done),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Pulse counters read the pre-edge value of each strobe, i.e. what the cycle just ending showed.
  always @(posedge clk) begin
    cyc++;
    if (write_line) wl_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_write_line"}, 32'(write_line), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Present a miss for one edge, then scramble the request inputs so that only latched values can be used.
  task automatic start_miss(input string tag, input logic [15:0] addr, input logic dirty,
                            input logic [12:0] vtag, input logic [7:0] vline);
    miss_req     = 1'b1;
    miss_address = addr;
    victim_dirty = dirty;
    victim_tag   = vtag;
    victim_line  = vline;
    step();
    miss_req     = 1'b0;
    miss_address = 16'hFFFF;
    victim_dirty = 1'b0;
    victim_tag   = 13'h1FFF;
    victim_line  = 8'h00;
    t0 = cyc;
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
  endtask

  // Runs one memory beat with the given number of wait cycles. It checks that the request holds steady every cycle.
  task automatic do_beat(input string tag, input logic we, input logic [15:0] addr,
                         input logic [3:0] wdata, input logic [3:0] rdata, input int waits);
    for (int i = 0; i < waits; i++) begin
      mem_ack   = 1'b0;
      mem_rdata = ~rdata;
      chk({tag, "_wait_req"}, 32'(mem_req), 32'd1);
      chk({tag, "_wait_we"}, 32'(mem_we), 32'(we));
      chk({tag, "_wait_addr"}, 32'(mem_addr), 32'(addr));
      if (we) chk({tag, "_wait_wdata"}, 32'(mem_wdata), 32'(wdata));
      step();
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_we"}, 32'(mem_we), 32'(we));
    chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
    if (we) chk({tag, "_wdata"}, 32'(mem_wdata), 32'(wdata));
    step();
  endtask

  task automatic finish_install(input string tag, input logic [7:0] line,
                                input logic [15:0] faddr, input int lat);
    mem_rdata = 4'h0;
    chk({tag, "_write_line"}, 32'(write_line), 32'd1);
    chk({tag, "_line_o"}, 32'(line_o), 32'(line));
    chk({tag, "_fill_address"}, 32'(fill_address), 32'(faddr));
    chk({tag, "_install_no_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_latency"}, 32'(cyc - t0), 32'(lat));
    step();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_wl_one_cycle"}, 32'(write_line), 32'd0);
    chk({tag, "_done_no_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd1);
    step();
    chk_idle({tag, "_after"});
    chk({tag, "_line_hold"}, 32'(line_o), 32'(line));
    chk({tag, "_faddr_hold"}, 32'(fill_address), 32'(faddr));
  endtask

  initial begin
    rst          = 1'b1;
    miss_req     = 1'b0;
    miss_address = 16'h0;
    victim_dirty = 1'b0;
    victim_tag   = 13'h0;
    victim_line  = 8'h0;
    mem_ack      = 1'b1;
    mem_rdata    = 4'h0;
    step();
    step();

    // Reset state: every output is zero.
    chk_idle("rst");
    chk("rst_line_o", 32'(line_o), 32'd0);
    chk("rst_fill_address", 32'(fill_address), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;
    step();
    step();
    chk_idle("idle_ack_high");
    chk("idle_wl_count", 32'(wl_cnt), 32'd0);

    // Clean miss, zero-wait memory.
    start_miss("clean", 16'h0025, 1'b0, 13'h0, 8'h00);
    do_beat("clean_b0", 1'b0, 16'h0024, 4'h0, 4'hA, 0);
    do_beat("clean_b1", 1'b0, 16'h0025, 4'h0, 4'h5, 0);
    finish_install("clean", 8'h5A, 16'h0024, 2);

    // Dirty miss: the victim is written back before the fill.
    start_miss("dirty", 16'h0025, 1'b1, 13'h7, 8'hC3);
    do_beat("dirty_wb0", 1'b1, 16'h003C, 4'h3, 4'h0, 0);
    do_beat("dirty_wb1", 1'b1, 16'h003D, 4'hC, 4'h0, 0);
    do_beat("dirty_f0", 1'b0, 16'h0024, 4'h0, 4'h1, 0);
    do_beat("dirty_f1", 1'b0, 16'h0025, 4'h0, 4'h9, 0);
    finish_install("dirty", 8'h91, 16'h0024, 4);

    // Dirty miss with three wait cycles on each beat.
    start_miss("wait", 16'h0013, 1'b1, 13'h1, 8'h6E);
    do_beat("wait_wb0", 1'b1, 16'h000A, 4'hE, 4'h0, 3);
    do_beat("wait_wb1", 1'b1, 16'h000B, 4'h6, 4'h0, 3);
    do_beat("wait_f0", 1'b0, 16'h0012, 4'h0, 4'h3, 3);
    do_beat("wait_f1", 1'b0, 16'h0013, 4'h0, 4'hD, 3);
    finish_install("wait", 8'hD3, 16'h0012, 16);

    // miss_req during FILL is ignored.
    wl_before   = wl_cnt;
    done_before = done_cnt;
    start_miss("ign", 16'h0025, 1'b0, 13'h0, 8'h00);
    miss_req     = 1'b1;
    miss_address = 16'h0013;
    victim_dirty = 1'b1;
    do_beat("ign_f0", 1'b0, 16'h0024, 4'h0, 4'hB, 1);
    miss_req     = 1'b0;
    victim_dirty = 1'b0;
    do_beat("ign_f1", 1'b0, 16'h0025, 4'h0, 4'h4, 0);
    finish_install("ign", 8'h4B, 16'h0024, 3);
    step();
    step();
    chk_idle("ign_quiet");
    chk("ign_wl_pulses", 32'(wl_cnt - wl_before), 32'd1);
    chk("ign_done_pulses", 32'(done_cnt - done_before), 32'd1);

    // Reset during WRITEBACK beat 1 abandons the operation.
    start_miss("abort", 16'h0025, 1'b1, 13'h7, 8'hC3);
    do_beat("abort_wb0", 1'b1, 16'h003C, 4'h3, 4'h0, 0);
    chk("abort_wb1_addr", 32'(mem_addr), 32'h003D);
    wl_before   = wl_cnt;
    done_before = done_cnt;
    rst     = 1'b1;
    mem_ack = 1'b0;
    step();
    chk_idle("abort_rst");
    chk("abort_line_o", 32'(line_o), 32'd0);
    chk("abort_fill_address", 32'(fill_address), 32'd0);
    rst     = 1'b0;
    mem_ack = 1'b1;
    step();
    step();
    chk_idle("abort_quiet");
    chk("abort_wl_pulses", 32'(wl_cnt - wl_before), 32'd0);
    chk("abort_done_pulses", 32'(done_cnt - done_before), 32'd0);

    // A clean miss after the abort completes normally.
    start_miss("post", 16'h0013, 1'b0, 13'h0, 8'h00);
    do_beat("post_f0", 1'b0, 16'h0012, 4'h0, 4'h7, 0);
    do_beat("post_f1", 1'b0, 16'h0013, 4'h0, 4'h2, 0);
    finish_install("post", 8'h27, 16'h0012, 2);

    // rst and miss_req together: reset wins.
    rst          = 1'b1;
    miss_req     = 1'b1;
    miss_address = 16'h0025;
    step();
    rst      = 1'b0;
    miss_req = 1'b0;
    chk_idle("rst_vs_req");
    chk("rst_vs_req_line_o", 32'(line_o), 32'd0);
    step();
    chk_idle("rst_vs_req_next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
